inc_arbiter: RTL and testbench
==============================

# inc_arbiter

Round-robin controller that shares one registered `inc16` incrementer between `NREQ` independent requesters. Each requester presents a `WIDTH`-bit operand with a valid/ready handshake. The arbiter grants one requester at a time and drives the operand into the incrementer. It waits the incrementer's fixed latency, then returns `operand + 1` tagged with the requester ID on a single valid/ready response channel. It sits between the requesting blocks and the `inc16` instance, whose `in_i`/`out_o` ports it fully owns.

## Interface
- `WIDTH`, 16: operand and result width; must match `inc16` `WIDTH`.
- `NREQ`, 4: number of requesters, 2..8.
- `INC_LATENCY`, 1: cycles from `inc_in_o` being stable at a clock edge to `inc_out_i` being valid; 1..7.
- `clk_i`, in, 1: single clock, rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `req_valid_i`, in, NREQ: per-requester operand valid.
- `req_data_i`, in, NREQ*WIDTH: operands; requester k uses bits [k*WIDTH +: WIDTH].
- `req_ready_o`, out, NREQ: one-hot grant/accept, combinational.
- `inc_in_o`, out, WIDTH: registered operand to `inc16.in_i`.
- `inc_out_i`, in, WIDTH: result from `inc16.out_o`.
- `rsp_valid_o`, out, 1: response valid.
- `rsp_ready_i`, in, 1: response consumer ready.
- `rsp_id_o`, out, $clog2(NREQ): index of the served requester.
- `rsp_data_o`, out, WIDTH: incremented result.
- `rsp_wrap_o`, out, 1: high when the operand was all-ones, so the result wrapped to 0.

## Operation
- FSM states: IDLE, WAIT, CAPTURE, RESP.
- IDLE:
  - If any `req_valid_i` is high, assert `req_ready_o` for exactly one requester, the winner.
  - The winner is the first valid index found searching upward from `rr_ptr`, modulo NREQ.
  - On that edge: `inc_in_o <= winner data`, `id <= winner`, `wrap <= &data`, `rr_ptr <= winner+1 mod NREQ`, counter `<= INC_LATENCY`, go to WAIT.
  - `req_ready_o` is all-zero outside IDLE.
- WAIT: decrement the counter each cycle; leave for CAPTURE when the counter reaches 1. `inc_in_o` is held constant.
- CAPTURE (one cycle): `rsp_data_o <= inc_out_i`, `rsp_valid_o <= 1`; go to RESP.
- RESP:
  - Hold `rsp_*` stable while `rsp_ready_i` is low.
  - On `rsp_valid_o && rsp_ready_i`: clear `rsp_valid_o` and go to IDLE.
- Arithmetic: the result is modulo 2^WIDTH, and the carry is not propagated. 0xFFFF gives 0x0000 with `rsp_wrap_o = 1`. The arbiter never computes the sum itself; it always uses `inc_out_i`.
- `rsp_wrap_o` and `rsp_id_o` are valid whenever `rsp_valid_o` is high.
- Requesters not granted keep `req_valid_i`/`req_data_i` stable; this is not checked.
- A requester dropping valid before grant is legal and is simply skipped.
- Reset, at any time including mid-transaction:
  - The in-flight transaction is abandoned and no response is produced.
  - State returns to IDLE; `rr_ptr = 0`.
  - `inc_in_o = 0`, `rsp_valid_o = 0`, `rsp_id_o = 0`, `rsp_data_o = 0`, `rsp_wrap_o = 0`, `req_ready_o = 0`.

## Timing
- Accept cycle T is the cycle where `req_valid_i[k] && req_ready_o[k]`.
- Pipeline for a request accepted in T:
  - `inc_in_o` is valid from T+1.
  - WAIT spans T+1..T+INC_LATENCY.
  - CAPTURE is T+INC_LATENCY+1.
  - `rsp_valid_o` goes high at T+INC_LATENCY+2.
- Default INC_LATENCY=1: accept in T, response valid in T+3.
- Earliest next accept is the cycle after the response handshake.
- Peak throughput is one operation per INC_LATENCY+3 cycles when `rsp_ready_i` is held high.
- Fairness: any continuously valid requester is granted within NREQ grants.
- Simultaneous events:
  - A request arriving during WAIT, CAPTURE or RESP waits in IDLE arbitration.
  - `rsp_ready_i` high before `rsp_valid_o` has no effect.
- `req_ready_o` depends only on state, `rr_ptr` and `req_valid_i`; it never depends on `rsp_ready_i`.

## Test plan
- Single request, INC_LATENCY=1: requester 2 presents 0x1234 → `req_ready_o` = 4'b0100 in accept cycle T; `rsp_valid_o` rises at T+3 with `rsp_data_o` = 0x1235, `rsp_id_o` = 2, `rsp_wrap_o` = 0.
- Round robin: all four requesters valid continuously with data 0x0010, 0x0020, 0x0030, 0x0040 → responses ID 0,1,2,3,0,… with data 0x0011, 0x0021, 0x0031, 0x0041; no requester is granted twice before all others.
- Wrap: requester 1 presents 0xFFFF → `rsp_data_o` = 0x0000, `rsp_wrap_o` = 1. Then 0x7FFF → 0x8000, `rsp_wrap_o` = 0.
- Backpressure: `rsp_ready_i` held low for 5 cycles after `rsp_valid_o` rises → `rsp_*` stable and `req_ready_o` = 0 throughout; the next grant occurs the cycle after `rsp_ready_i` rises.
- Reset mid-operation: assert `rst_i` during WAIT → all outputs read 0 immediately; no response is emitted; after release, a pending requester 3 is granted only if requesters 0–2 are idle, since `rr_ptr` is 0.
- Latency parameter INC_LATENCY=3, with an `inc16` delayed by 3 stages: operand 0x00FF → response 0x0100 exactly 5 cycles after the accept cycle.

Source files
------------

// File: rtl/inc_arbiter.sv
// Round-robin controller that time-shares one registered incrementer among
// NREQ requesters and returns operand+1, tagged with the requester id.
module inc_arbiter #(
  parameter int WIDTH       = 16,
  parameter int NREQ        = 4,
  parameter int INC_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*WIDTH-1:0]   req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic [WIDTH-1:0]        inc_in_o,
  input  logic [WIDTH-1:0]        inc_out_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [$clog2(NREQ)-1:0] rsp_id_o,
  output logic [WIDTH-1:0]        rsp_data_o,
  output logic                    rsp_wrap_o
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = 3;

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] next_ptr;
  logic [CW-1:0]  cnt;
  logic           found;
  logic [WIDTH-1:0] win_data;
  int             idx;

  // Search upward from rr_ptr, wrapping modulo NREQ; first valid index wins.
  // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_data = '0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!found && req_valid_i[idx]) begin
        found    = 1'b1;
        winner   = IDW'(idx);
        win_data = req_data_i[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign next_ptr = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

  // Grant is purely a function of state, pointer and valids; reset forces it low.
  always_comb begin
    req_ready_o = '0;
    if (!rst_i && state == IDLE && found)
      req_ready_o[winner] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      inc_in_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      rsp_wrap_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            inc_in_o   <= win_data;
            rsp_id_o   <= winner;
            rsp_wrap_o <= &win_data;
            rr_ptr     <= next_ptr;
            cnt        <= CW'(INC_LATENCY);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CW'(1))
            state <= CAPTURE;
          else
            cnt <= cnt - 1'b1;
        end
        CAPTURE: begin
          rsp_data_o  <= inc_out_i;
          rsp_valid_o <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inc_arbiter.sv
// Bench for inc_arbiter: scoreboard plus round-robin model for the default
// build, and a directed latency check on an INC_LATENCY=3 build.
module tb_inc_arbiter;

  localparam int W = 16;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic        wrap;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   inc_in, inc_out, rsp_data;
  logic           rsp_valid, rsp_ready, rsp_wrap;
  logic [1:0]     rsp_id;

  logic [N-1:0]   req_valid3, req_ready3;
  logic [N*W-1:0] req_data3;
  logic [W-1:0]   inc_in3, inc_out3, rsp_data3;
  logic           rsp_valid3, rsp_ready3, rsp_wrap3;
  logic [1:0]     rsp_id3;

  inc_arbiter #(.WIDTH(W), .NREQ(N), .INC_LATENCY(1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .inc_in_o(inc_in), .inc_out_i(inc_out),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_wrap_o(rsp_wrap)
  );

  inc_arbiter #(.WIDTH(W), .NREQ(N), .INC_LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid3), .req_data_i(req_data3), .req_ready_o(req_ready3),
    .inc_in_o(inc_in3), .inc_out_i(inc_out3),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3),
    .rsp_id_o(rsp_id3), .rsp_data_o(rsp_data3), .rsp_wrap_o(rsp_wrap3)
  );

  // Incrementer models: one registered stage, and a three-stage delayed one.
  logic [W-1:0] pipe3 [3];
  always @(posedge clk) begin
    inc_out  <= inc_in + 16'd1;
    pipe3[0] <= inc_in3 + 16'd1;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign inc_out3 = pipe3[2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_count = 0;
  int acc_cyc = 0;
  int ptr = 0;
  int exp_id = 0;
  int k_m = 0;
  bit busy = 1'b0;
  bit prev_valid = 1'b0;
  logic [N-1:0] exp_ready;
  logic [W-1:0] d;
  rsp_t exp_q[$];
  rsp_t exp3_q[$];
  rsp_t log_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model for the default build: round-robin grant, busy tracking,
  // expected response queue and accept-to-valid latency.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      busy       = 1'b0;
      ptr        = 0;
      prev_valid = 1'b0;
    end else begin
      exp_ready = '0;
      exp_id    = 0;
      if (!busy) begin
        for (int i = 0; i < N; i++) begin
          k_m = (ptr + i) % N;
          if (exp_ready == '0 && req_valid[k_m]) begin
            exp_ready[k_m] = 1'b1;
            exp_id         = k_m;
          end
        end
      end
      check("req_ready", req_ready, exp_ready);
      if (exp_ready != '0) begin
        d = req_data[exp_id*W +: W];
        exp_q.push_back('{id: 2'(exp_id), data: d + 16'd1, wrap: (d == 16'hFFFF)});
        acc_cyc = cyc;
        ptr     = (exp_id + 1) % N;
        busy    = 1'b1;
      end
      if (rsp_valid) begin
        check("rsp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("rsp_id", rsp_id, exp_q[0].id);
          check("rsp_data", rsp_data, exp_q[0].data);
          check("rsp_wrap", rsp_wrap, exp_q[0].wrap);
          if (!prev_valid) check("rsp_latency", cyc - acc_cyc, 3);
          if (rsp_ready) begin
            log_q.push_back('{id: rsp_id, data: rsp_data, wrap: rsp_wrap});
            void'(exp_q.pop_front());
            busy = 1'b0;
            rsp_count++;
          end
        end
      end
      prev_valid = rsp_valid;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp3_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid3[i] && req_ready3[i]) begin
          d = req_data3[i*W +: W];
          exp3_q.push_back('{id: 2'(i), data: d + 16'd1, wrap: (d == 16'hFFFF)});
        end
      end
      if (rsp_valid3 && rsp_ready3) begin
        check("rsp3_pending", exp3_q.size() > 0, 1);
        if (exp3_q.size() > 0) begin
          check("rsp3_id", rsp_id3, exp3_q[0].id);
          check("rsp3_data", rsp_data3, exp3_q[0].data);
          check("rsp3_wrap", rsp_wrap3, exp3_q[0].wrap);
          void'(exp3_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand, wait for its grant, then drop valid.
  task automatic issue(input int k, input logic [15:0] v);
    bit got;
    got = 1'b0;
    req_data[k*W +: W] = v;
    req_valid[k] = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[k]) got = 1'b1;
      else tick();
    end
    check("grant_timeout", got, 1);
    tick();
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_count < target && n < 200) begin
      tick();
      n++;
    end
    check("rsp_timeout", rsp_count >= target, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    int acc3;

    rst        = 1'b1;
    rsp_ready  = 1'b1;
    rsp_ready3 = 1'b1;
    req_valid  = 4'hF;
    req_data   = '0;
    req_valid3 = '0;
    req_data3  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_inc_in", inc_in, 16'h0000);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    check("rst_rsp_wrap", rsp_wrap, 0);
    check("rst_rsp_valid3", rsp_valid3, 0);
    rst       = 1'b0;
    req_valid = '0;
    tick();

    // Single request from requester 2, response three cycles after accept.
    req_data[2*W +: W] = 16'h1234;
    req_valid = 4'b0100;
    @(negedge clk);
    check("t1_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t1_inc_in", inc_in, 16'h1234);
    check("t1_valid_t1", rsp_valid, 0);
    tick();
    @(negedge clk);
    check("t1_valid_t2", rsp_valid, 0);
    tick();
    @(negedge clk);
    check("t1_valid_t3", rsp_valid, 1);
    check("t1_data", rsp_data, 16'h1235);
    check("t1_id", rsp_id, 2);
    check("t1_wrap", rsp_wrap, 0);
    tick();

    // Round robin from a fresh pointer with all four requesters valid.
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    log_q.delete();
    req_data  = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    req_valid = 4'hF;
    base = rsp_count;
    wait_rsp(base + 8);
    req_valid = '0;
    check("rr_count", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      check("rr_id", log_q[i].id, i % 4);
      check("rr_data", log_q[i].data, 16'h0011 + 16'(16 * (i % 4)));
    end

    // Wrap-around and top-bit carry.
    log_q.delete();
    base = rsp_count;
    issue(1, 16'hFFFF);
    wait_rsp(base + 1);
    issue(1, 16'h7FFF);
    wait_rsp(base + 2);
    check("wrap_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("wrap_data", log_q[0].data, 16'h0000);
      check("wrap_flag", log_q[0].wrap, 1);
      check("carry_data", log_q[1].data, 16'h8000);
      check("carry_flag", log_q[1].wrap, 0);
    end

    // Backpressure with a second requester waiting.
    rsp_ready = 1'b0;
    base = rsp_count;
    issue(0, 16'h0ABC);
    req_data[2*W +: W] = 16'h0555;
    req_valid[2] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("bp_valid_rise", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("bp_valid_hold", rsp_valid, 1);
      check("bp_data_hold", rsp_data, 16'h0ABD);
      check("bp_ready_low", req_ready, 4'b0000);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_handshake", req_ready, 4'b0000);
    tick();
    @(negedge clk);
    check("bp_next_grant", req_ready, 4'b0100);
    tick();
    req_valid[2] = 1'b0;
    wait_rsp(base + 2);

    // Reset during WAIT abandons the transaction and clears the pointer.
    issue(1, 16'h0101);
    rst = 1'b1;
    #1;
    check("mid_rst_inc_in", inc_in, 16'h0000);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_id", rsp_id, 0);
    check("mid_rst_data", rsp_data, 16'h0000);
    check("mid_rst_wrap", rsp_wrap, 0);
    check("mid_rst_ready", req_ready, 4'b0000);
    @(negedge clk);
    tick();
    rst = 1'b0;
    check("post_rst_valid", rsp_valid, 0);
    log_q.delete();
    base = rsp_count;
    req_data[1*W +: W] = 16'h2222;
    req_data[3*W +: W] = 16'h3333;
    req_valid = 4'b1010;
    @(negedge clk);
    check("post_rst_grant", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(base + 2);
    req_valid = '0;
    check("post_rst_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("post_rst_first", log_q[0].id, 1);
      check("post_rst_second", log_q[1].id, 3);
      check("post_rst_data3", log_q[1].data, 16'h3334);
    end

    // Three-stage incrementer: response valid five cycles after accept.
    req_data3[0 +: W] = 16'h00FF;
    req_valid3 = 4'b0001;
    @(negedge clk);
    check("l3_ready", req_ready3, 4'b0001);
    acc3 = cyc;
    tick();
    req_valid3 = '0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid3 && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("l3_latency", cyc - acc3, 5);
    check("l3_data", rsp_data3, 16'h0100);
    check("l3_id", rsp_id3, 0);
    check("l3_wrap", rsp_wrap3, 0);
    repeat (3) tick();

    check("sb_empty", exp_q.size(), 0);
    check("sb3_empty", exp3_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
